// File: rtl/regfile_pkg.sv
// Shared constants for the register file write path: widths, PC address,
// write-arbiter FSM encoding and requester identifiers.
package regfile_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   // R7 is the PC and is written by a dedicated path elsewhere
   localparam logic [2:0] PC_REG_ADDR = 3'd7;

   // Write-arbiter FSM states
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // Requester IDs; also the bit index in the arbiter req/gnt vectors
   localparam logic REQ_C = 1'b0;
   localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter. On a conflict the requester
// that did not win last time is picked; a lone request always wins.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       winner
);

   // Pick the winner and raise its grant bit
   always_comb begin
      gnt    = 2'b00;
      winner = REQ_C;
      if (req == 2'b11)
         winner = ~last;
      else if (req[REQ_D])
         winner = REQ_D;
      if (req != 2'b00)
         gnt[winner] = 1'b1;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port. Round-robins core writeback and
// debug/loader writes, and runs a bulk-clear sweep over R0..R(NUM_WREGS-1).
// Writes aimed at the PC address are granted but suppressed and flagged.
module regfile_write_arbiter #(
   parameter int                   DATA_W    = regfile_pkg::DATA_W,
   parameter int                   ADDR_W    = regfile_pkg::ADDR_W,
   parameter int                   NUM_WREGS = 7,
   parameter logic [DATA_W-1:0]    CLR_VAL   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_data,
   output logic              c_gnt,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data,
   output logic              d_gnt,
   input  logic              clr_start,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd3,
   output logic              busy,
   output logic              wr_err
);

   import regfile_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WREGS - 1);
   localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_REG_ADDR);

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_idx;
   logic              last;
   logic [1:0]        arb_gnt;
   logic              winner;
   logic              arb_en;
   logic              conflict;
   wr_t               c_wr, d_wr, sel;

   assign c_wr = '{addr: c_addr, data: c_data};
   assign d_wr = '{addr: d_addr, data: d_data};

   rr_arb2 u_arb (
      .req    ({d_req, c_req}),
      .last   (last),
      .gnt    (arb_gnt),
      .winner (winner)
   );

   // Grants only in IDLE, never during reset, and a clear request pre-empts
   // arbitration so the losing request simply stays pending
   assign arb_en   = !reset && (state == ST_IDLE) && !clr_start;
   assign c_gnt    = arb_en & arb_gnt[REQ_C];
   assign d_gnt    = arb_en & arb_gnt[REQ_D];
   assign conflict = c_req & d_req;
   assign sel      = (winner == REQ_D) ? d_wr : c_wr;

   // FSM, clear counter, round-robin history and registered write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         clr_idx <= '0;
         last    <= REQ_D;
         rf_wen  <= 1'b0;
         rf_a3   <= '0;
         rf_wd3  <= '0;
         busy    <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         rf_wen <= 1'b0;
         wr_err <= 1'b0;
         busy   <= 1'b0;
         if (state == ST_CLEAR) begin
            rf_a3  <= clr_idx;
            rf_wd3 <= CLR_VAL;
            rf_wen <= 1'b1;
            busy   <= 1'b1;
            if (clr_idx == LAST_IDX) begin
               state   <= ST_IDLE;
               clr_idx <= '0;
            end else begin
               clr_idx <= clr_idx + 1'b1;
            end
         end else if (clr_start) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
         end else if (c_gnt || d_gnt) begin
            // address/data track the granted write even when it is suppressed
            rf_a3  <= sel.addr;
            rf_wd3 <= sel.data;
            rf_wen <= (sel.addr != PC_ADDR);
            wr_err <= (sel.addr == PC_ADDR);
            if (conflict)
               last <= winner;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: scoreboard of expected register-file
// writes, a behavioural 8x8 register file on the write port, and one task
// per scenario.
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       c_req = 1'b0, d_req = 1'b0, clr_start = 1'b0;
   logic [2:0] c_addr = '0, d_addr = '0;
   logic [7:0] c_data = '0, d_data = '0;
   logic       c_gnt, d_gnt, rf_wen, busy, wr_err;
   logic [2:0] rf_a3;
   logic [7:0] rf_wd3;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] a;
      logic [7:0] d;
      logic       wen;
      logic       err;
      logic       bsy;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] rf_mem [8];
   logic       exp_last;   // 0 = core, 1 = debug

   regfile_write_arbiter #(
      .DATA_W(8), .ADDR_W(3), .NUM_WREGS(7), .CLR_VAL(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_addr(c_addr), .c_data(c_data), .c_gnt(c_gnt),
      .d_req(d_req), .d_addr(d_addr), .d_data(d_data), .d_gnt(d_gnt),
      .clr_start(clr_start),
      .rf_wen(rf_wen), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
      .busy(busy), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   // Register file: commits one edge after the arbiter registers the write
   initial begin
      for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;
      rf_mem[7] = 8'h77;
   end
   always @(posedge clk) if (rf_wen) rf_mem[rf_a3] <= rf_wd3;

   // Monitor: every write-port activity must match the next scoreboard entry
   always @(negedge clk) begin
      if (!reset && (rf_wen || wr_err || busy)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got a3=%0d wd3=%h wen=%b err=%b busy=%b required no activity",
                     rf_a3, rf_wd3, rf_wen, wr_err, busy);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({rf_a3, rf_wd3, rf_wen, wr_err, busy} !== {e.a, e.d, e.wen, e.err, e.bsy}) begin
               failures++;
               $display("FAIL write_port got a3=%0d wd3=%h wen=%b err=%b busy=%b required a3=%0d wd3=%h wen=%b err=%b busy=%b",
                        rf_a3, rf_wd3, rf_wen, wr_err, busy, e.a, e.d, e.wen, e.err, e.bsy);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_clear();
      for (int i = 0; i < 7; i++) exp_q.push_back('{a: 3'(i), d: 8'hFF, wen: 1'b1, err: 1'b0, bsy: 1'b1});
   endtask

   task automatic test_reset();
      c_req = 1'b1; d_req = 1'b1;
      #12;
      checks++;
      if ({c_gnt, d_gnt, rf_wen, busy, wr_err, rf_a3, rf_wd3} !== 16'h0) begin
         failures++;
         $display("FAIL reset_state got gnt=%b%b wen=%b busy=%b err=%b a3=%0d wd3=%h required all zero",
                  c_gnt, d_gnt, rf_wen, busy, wr_err, rf_a3, rf_wd3);
      end
      c_req = 1'b0; d_req = 1'b0;
      step();
      reset = 1'b0;
      exp_last = 1'b1;
      step();
   endtask

   task automatic test_single_core();
      c_req = 1'b1; c_addr = 3'd3; c_data = 8'h5A;
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt} !== 2'b10) begin
         failures++;
         $display("FAIL single_core_gnt got c=%b d=%b required c=1 d=0", c_gnt, d_gnt);
      end
      exp_q.push_back('{a: 3'd3, d: 8'h5A, wen: 1'b1, err: 1'b0, bsy: 1'b0});
      step();
      c_req = 1'b0;
      step();
      checks++;
      if (rf_mem[3] !== 8'h5A) begin
         failures++;
         $display("FAIL single_core_rd got %h required 5a", rf_mem[3]);
      end
   endtask

   task automatic test_back_to_back();
      logic       w;
      logic [7:0] ck = 8'hA0, dk = 8'hB0;
      c_addr = 3'd1; d_addr = 3'd2;
      for (int i = 0; i < 4; i++) begin
         c_req = 1'b1; d_req = 1'b1; c_data = ck; d_data = dk;
         w = ~exp_last;
         @(negedge clk);
         checks++;
         if ({c_gnt, d_gnt} !== {~w, w}) begin
            failures++;
            $display("FAIL conflict_gnt%0d got c=%b d=%b required c=%b d=%b", i, c_gnt, d_gnt, ~w, w);
         end
         exp_q.push_back('{a: w ? 3'd2 : 3'd1, d: w ? dk : ck, wen: 1'b1, err: 1'b0, bsy: 1'b0});
         exp_last = w;
         step();
         if (w) dk = dk + 8'h01; else ck = ck + 8'h01;
      end
      c_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   task automatic test_addr7();
      d_req = 1'b1; d_addr = 3'd7; d_data = 8'hEE;
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt} !== 2'b01) begin
         failures++;
         $display("FAIL addr7_gnt got c=%b d=%b required c=0 d=1", c_gnt, d_gnt);
      end
      exp_q.push_back('{a: 3'd7, d: 8'hEE, wen: 1'b0, err: 1'b1, bsy: 1'b0});
      step();
      d_req = 1'b0;
      step();
      step();
      checks++;
      if (rf_mem[7] !== 8'h77) begin
         failures++;
         $display("FAIL addr7_pc got %h required 77", rf_mem[7]);
      end
   endtask

   task automatic test_clear_core();
      c_req = 1'b1; c_addr = 3'd5; c_data = 8'h3C; clr_start = 1'b1;
      @(negedge clk);
      checks++;
      if (c_gnt !== 1'b0) begin
         failures++;
         $display("FAIL clear_start_gnt got c=%b required 0", c_gnt);
      end
      push_clear();
      step();
      clr_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (c_gnt !== 1'b0) begin
            failures++;
            $display("FAIL clear_sweep_gnt%0d got c=%b required 0", i, c_gnt);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (c_gnt !== 1'b1) begin
         failures++;
         $display("FAIL clear_after_gnt got c=%b required 1", c_gnt);
      end
      exp_q.push_back('{a: 3'd5, d: 8'h3C, wen: 1'b1, err: 1'b0, bsy: 1'b0});
      step();
      c_req = 1'b0;
      step();
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rf_mem[i] !== ((i == 5) ? 8'h3C : 8'hFF)) begin
            failures++;
            $display("FAIL clear_contents R%0d got %h required %h", i, rf_mem[i], (i == 5) ? 8'h3C : 8'hFF);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      clr_start = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back('{a: 3'(i), d: 8'hFF, wen: 1'b1, err: 1'b0, bsy: 1'b1});
      step();
      clr_start = 1'b0;
      step(); step(); step();
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({rf_wen, busy, wr_err, rf_a3} !== 6'b0) begin
         failures++;
         $display("FAIL reset_mid got wen=%b busy=%b err=%b a3=%0d required zeros", rf_wen, busy, wr_err, rf_a3);
      end
      exp_q.delete();
      step();
      reset = 1'b0;
      exp_last = 1'b1;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_clear_debug();
      d_req = 1'b1; d_addr = 3'd4; d_data = 8'h44; clr_start = 1'b1;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b0) begin
         failures++;
         $display("FAIL clr_dbg_start got d=%b required 0", d_gnt);
      end
      push_clear();
      step();
      clr_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL clr_dbg_sweep%0d got d=%b required 0", i, d_gnt);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
         failures++;
         $display("FAIL clr_dbg_after got d=%b required 1", d_gnt);
      end
      exp_q.push_back('{a: 3'd4, d: 8'h44, wen: 1'b1, err: 1'b0, bsy: 1'b0});
      step();
      d_req = 1'b0;
      for (int i = 0; i < 3; i++) step();
   endtask

   initial begin
      test_reset();
      test_single_core();
      test_back_to_back();
      test_addr7();
      test_clear_core();
      test_reset_mid_clear();
      test_clear_debug();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_writes got %0d pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
